skid_slice: RTL and testbench
=============================

SKID_SLICE -- requirements
Module: skid_slice

Interface
REQ-001 Parameter WIDTH, default 3: payload width in bits; legal values are 1..64.
REQ-002 Parameter CNT_W, default 16: width of the transfer counter.
REQ-003 i_clk  input  1  sole clock; all state updates on posedge.
REQ-004 i_arst  input  1  reset, asynchronous, active-high; there is no synchronous reset port.
REQ-005 i_valid  input  1  upstream payload valid.
REQ-006 o_ready  output  1  slice can accept; registered.
REQ-007 i_data  input  WIDTH  upstream payload.
REQ-008 o_valid  output  1  downstream payload valid; registered.
REQ-009 i_ready  input  1  downstream accepts.
REQ-010 o_data  output  WIDTH  downstream payload; registered.
REQ-011 o_count  output  2  occupancy: 0, 1 or 2 entries.
REQ-012 o_nXfer  output  CNT_W  count of completed downstream transfers.

Function
REQ-013 An upstream transfer shall occur when i_valid && o_ready at a posedge.
REQ-014 A downstream transfer shall occur when o_valid && i_ready at a posedge.
REQ-015 The FSM shall have three states: EMPTY (0 entries), BUSY (main register valid), FULL (main and skid registers valid).
REQ-016 EMPTY: on an upstream transfer, main <= i_data and go to BUSY; otherwise hold.
REQ-017 BUSY, upstream and downstream transfer together: main <= i_data; stay in BUSY.
REQ-018 BUSY, upstream transfer only: skid <= i_data; go to FULL.
REQ-019 BUSY, downstream transfer only: go to EMPTY.
REQ-020 FULL: upstream transfer is impossible because o_ready is 0.
REQ-021 FULL, downstream transfer: main <= skid; go to BUSY.
REQ-022 Decode: o_valid = (state != EMPTY); o_ready = (state != FULL); o_data = main; o_count = 0, 1 or 2 per state. All of these shall be registered, with no combinational path from any input to any output.
REQ-023 Latency: a payload accepted at edge N shall appear on o_data with o_valid=1 after edge N, provided the slice was EMPTY or BUSY-with-drain.
REQ-024 Throughput: one transfer per cycle in steady state when i_valid=i_ready=1 throughout.
REQ-025 Ordering: payloads shall leave in acceptance order; none shall be dropped or duplicated.
REQ-026 o_data shall be held stable while o_valid=1 and i_ready=0.
REQ-027 In EMPTY, o_data shall hold its last value and its content is don't-care.
REQ-028 o_nXfer shall increment by 1 on every downstream transfer and wrap from 2^CNT_W-1 to 0.
REQ-029 i_data and i_valid shall be ignored whenever o_ready=0.

Reset
REQ-030 While i_arst=1: state=EMPTY, o_valid=0, o_ready=0, o_data=0, skid=0, o_count=0, o_nXfer=0, applied asynchronously.
REQ-031 o_ready shall go to 1 at the first posedge after i_arst deasserts.
REQ-032 Asserting i_arst mid-operation shall discard all held payloads immediately, with no downstream transfer for them.

Structure
REQ-033 Package skid_slice_pkg shall hold the state typedef (EMPTY, BUSY, FULL as a 2-bit enum) and the occupancy-width constant.
REQ-034 The block shall be a single module with no sub-module; main and skid are plain registers.

Verification
REQ-035 Reset release, then i_valid=1 with i_data=3'b101 and i_ready=1 -> o_valid=1, o_data=101 one cycle later; o_nXfer=1 after the next edge.
REQ-036 i_ready=0; push 3'b001 then 3'b010 -> o_count=2, o_ready=0; then i_ready=1 -> 001 then 010 delivered on consecutive cycles, o_ready=1 again after the first pop.
REQ-037 Stream 8 values 0..7 with i_valid=i_ready=1 -> output matches 0..7 in order at 1 per cycle, o_count stays 1.
REQ-038 i_ready toggled randomly for 1000 cycles against a reference queue -> no loss, no duplication, o_data stable while stalled.
REQ-039 CNT_W=4; perform 17 transfers -> o_nXfer=1 (wrapped).
REQ-040 Assert i_arst while FULL -> o_valid=0 and o_count=0 without waiting for a clock edge; o_ready=1 one edge after release.

Source files
------------

// File: rtl/skid_slice_pkg.sv
//------------------------------------------------------------------------------
// skid_slice_pkg
// Shared state encoding and occupancy helpers for the skid_slice register slice.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package skid_slice_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [OCC_W-1:0] occ_of(input state_t st);
        case (st)
            ST_BUSY: occ_of = OCC_W'(1);
            ST_FULL: occ_of = OCC_W'(2);
            default: occ_of = OCC_W'(0);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/skid_slice.sv
//------------------------------------------------------------------------------
// skid_slice
// Two-entry valid/ready register slice with fully registered outputs and a
// wrapping count of completed downstream transfers.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module skid_slice
    import skid_slice_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [OCC_W-1:0] o_count,
    output logic [CNT_W-1:0] o_nXfer
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic [WIDTH-1:0]   w_main_nxt;
    logic [WIDTH-1:0]   w_skid_nxt;
    logic               r_valid;
    logic               r_ready;
    logic [OCC_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_nxfer;
    logic               w_up;
    logic               w_dn;

    // Handshakes use only registered outputs, so no input reaches an output combinationally.
    assign w_up = i_valid & r_ready;
    assign w_dn = r_valid & i_ready;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_up) begin
                    w_main_nxt  = i_data;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_up && w_dn) begin
                    w_main_nxt = i_data;
                end else if (w_up) begin
                    w_skid_nxt  = i_data;
                    w_state_nxt = ST_FULL;
                end else if (w_dn) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_dn) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_main  <= '0;
            r_skid  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_count <= '0;
            r_nxfer <= '0;
        end else begin
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_valid <= (w_state_nxt != ST_EMPTY);
            r_ready <= (w_state_nxt != ST_FULL);
            r_count <= occ_of(w_state_nxt);
            if (w_dn) begin
                r_nxfer <= r_nxfer + CNT_W'(1);
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_main;
    assign o_count = r_count;
    assign o_nXfer = r_nxfer;

endmodule

`default_nettype wire

// File: tb/tb_skid_slice.sv
//------------------------------------------------------------------------------
// tb_skid_slice
// Directed and random stimulus against a queue model of a two-entry slice.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_skid_slice;

    localparam int WIDTH = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             arst;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_count;
    logic [CNT_W-1:0] out_nxfer;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a FIFO of held payloads, the last payload presented, a transfer count.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] shown;
    int               nx;
    bit               rdy_ok;

    skid_slice #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_arst  (arst),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_data  (in_data),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_data  (out_data),
        .o_count (out_count),
        .o_nXfer (out_nxfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return rdy_ok && (q.size() < 2);
    endfunction

    task automatic model_clear();
        q.delete();
        shown  = '0;
        nx     = 0;
        rdy_ok = 1'b0;
    endtask

    task automatic model_check();
        chk("valid", 64'(out_valid), 64'(q.size() > 0));
        chk("ready", 64'(out_ready), 64'(exp_ready()));
        chk("data",  64'(out_data),  64'(shown));
        chk("count", 64'(out_count), 64'(q.size()));
        chk("nxfer", 64'(out_nxfer), 64'(nx % (1 << CNT_W)));
    endtask

    // One clock: handshakes decided from model outputs, model advanced, then checked at negedge.
    task automatic step();
        bit up;
        bit dn;
        up = in_valid && exp_ready();
        dn = (q.size() > 0) && in_ready;
        @(posedge clk);
        if (dn) begin
            void'(q.pop_front());
            nx++;
        end
        if (up) q.push_back(in_data);
        rdy_ok = 1'b1;
        if (q.size() > 0) shown = q[0];
        @(negedge clk);
        model_check();
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        in_ready = r;
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #2;
        arst = 1'b1;
        #1;
        model_clear();
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(out_count), 64'd0);
        chk("arst_ready", 64'(out_ready), 64'd0);
        chk("arst_data",  64'(out_data),  64'd0);
        chk("arst_nxfer", 64'(out_nxfer), 64'd0);
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("rel_ready_low", 64'(out_ready), 64'd0);
        drive(1'b0, '0, 1'b0);
        step();
        chk("rel_ready_high", 64'(out_ready), 64'd1);
    endtask

    initial begin
        arst = 1'b1;
        drive(1'b0, '0, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(out_ready), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        @(negedge clk);
        arst = 1'b0;
        step();
        chk("first_ready", 64'(out_ready), 64'd1);

        // Single payload passes straight through.
        drive(1'b1, 3'b101, 1'b1);
        step();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data",  64'(out_data),  64'b101);
        drive(1'b0, '0, 1'b1);
        step();
        chk("lat_nxfer", 64'(out_nxfer), 64'd1);

        // Fill both entries while stalled, then drain.
        drive(1'b1, 3'b001, 1'b0);
        step();
        drive(1'b1, 3'b010, 1'b0);
        step();
        chk("full_count", 64'(out_count), 64'd2);
        chk("full_ready", 64'(out_ready), 64'd0);
        chk("full_head",  64'(out_data),  64'b001);
        drive(1'b1, 3'b111, 1'b1);
        step();
        chk("pop1_data",  64'(out_data),  64'b010);
        chk("pop1_ready", 64'(out_ready), 64'd1);
        chk("pop1_count", 64'(out_count), 64'd1);
        drive(1'b0, '0, 1'b1);
        step();
        chk("pop2_valid", 64'(out_valid), 64'd0);
        chk("pop2_data",  64'(out_data),  64'b010);

        // Streaming at full rate.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, WIDTH'(k), 1'b1);
            step();
            chk("stream_data",  64'(out_data),  64'(k));
            chk("stream_count", 64'(out_count), 64'd1);
        end
        drive(1'b0, '0, 1'b1);
        step();

        // Random handshakes against the queue model.
        for (int k = 0; k < 1000; k++) begin
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            step();
        end

        // Reset while holding two entries.
        drive(1'b1, 3'b011, 1'b0);
        step();
        step();
        step();
        chk("pre_rst_count", 64'(out_count), 64'd2);
        async_reset();

        // 17 transfers wrap a 4-bit counter to 1.
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, WIDTH'(k), 1'b1);
            step();
        end
        drive(1'b0, '0, 1'b1);
        step();
        chk("wrap_nxfer", 64'(out_nxfer), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
